div_int_iter: RTL and testbench

//  Iterative radix-2 non-restoring integer divider, the inverse counterpart of the mul_int multiplier datapath.

---
 rtl/div_int_pkg.sv | 19 +
 rtl/div_int_if.sv | 23 ++
 rtl/div_int_step.sv | 20 ++
 rtl/div_int_iter.sv | 159 +++++++++++++++
 tb/tb_div_int_iter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/div_int_pkg.sv
// Shared constants for the iterative divider: FSM state codes, counter sizing, MIN helper.
package div_int_pkg;
  localparam int DEF_WIDTH = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Most negative two's-complement value of a w-bit word (w <= 64), zero-extended.
  function automatic logic [63:0] min_of(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/div_int_if.sv
// Operand/result handshake bundle between the execute stage and the divider.
interface div_int_if import div_int_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_zero;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, kill, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero
  );
  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, kill, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_zero
  );
endinterface

// File: rtl/div_int_step.sv
// One radix-2 non-restoring iteration on a WIDTH+1 bit signed partial remainder.
module div_int_step import div_int_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh;
  logic [WIDTH:0] d;

  // Doubling may wrap WIDTH+1 bits, but the post-add/sub value is in range, so the
  // add/sub decision must come from the pre-shift sign.
  assign sh    = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign d     = {1'b0, dvs_i};
  assign rem_o = rem_i[WIDTH] ? (sh + d) : (sh - d);
  assign quo_o = {quo_i[WIDTH-2:0], ~rem_o[WIDTH]};
endmodule

// File: rtl/div_int_iter.sv
// Iterative radix-2 non-restoring divider with RISC-V DIV/REM semantics.
// Optional DIV_INT_EARLY_OUT_EN: skip leading-zero iterations of |dividend|.
module div_int_iter import div_int_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     clock,
  input  logic     reset,
  div_int_if.slave bus
);
  localparam int               CW  = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN = WIDTH'(min_of(WIDTH));

  logic [2:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] qo_q, qo_d;
  logic [WIDTH-1:0] ro_q, ro_d;
  logic             dzo_q, dzo_d;

  logic [WIDTH:0]   rem_nx, rem_fix;
  logic [WIDTH-1:0] quo_nx;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] dvd_pre;
  logic [CW-1:0]    iters;

  div_int_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // During PREP quo_q/dvs_q still hold the raw operands latched at accept.
  assign dvd_neg = sgn_q & quo_q[WIDTH-1];
  assign dvs_neg = sgn_q & dvs_q[WIDTH-1];
  assign dvd_abs = dvd_neg ? -quo_q : quo_q;
  assign dvs_abs = dvs_neg ? -dvs_q : dvs_q;
  assign rem_fix = rem_q[WIDTH] ? (rem_q + {1'b0, dvs_q}) : rem_q;

`ifdef DIV_INT_EARLY_OUT_EN
  logic [CW-1:0] blen;
  always_comb begin
    blen = CW'(1);
    for (int i = 0; i < WIDTH; i++)
      if (dvd_abs[i]) blen = CW'(i + 1);
  end
  assign iters   = blen;
  assign dvd_pre = dvd_abs << (CW'(WIDTH) - blen);
`else
  assign iters   = CW'(WIDTH);
  assign dvd_pre = dvd_abs;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dzo_d   = dzo_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = ST_PREP;
        quo_d   = bus.in_dividend;
        dvs_d   = bus.in_divisor;
        sgn_d   = bus.in_signed;
      end
      ST_PREP: begin
        dz_d   = 1'b0;
        negq_d = 1'b0;
        negr_d = 1'b0;
        // Special results go through FIX with a non-negative remainder so no correction applies.
        if (dvs_q == '0) begin
          state_d = ST_FIX;
          quo_d   = '1;
          rem_d   = {1'b0, quo_q};
          dz_d    = 1'b1;
        end else if (sgn_q && quo_q == MIN && dvs_q == '1) begin
          state_d = ST_FIX;
          quo_d   = MIN;
          rem_d   = '0;
        end else begin
          state_d = ST_CALC;
          rem_d   = '0;
          quo_d   = dvd_pre;
          dvs_d   = dvs_abs;
          cnt_d   = iters;
          negq_d  = dvd_neg ^ dvs_neg;
          negr_d  = dvd_neg;
        end
      end
      ST_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        qo_d    = negq_q ? -quo_q : quo_q;
        ro_d    = negr_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
        dzo_d   = dz_q;
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.kill) state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      qo_q    <= '0;
      ro_q    <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.in_ready      = (state_q == ST_IDLE);
  assign bus.out_valid     = (state_q == ST_DONE);
  assign bus.out_quotient  = qo_q;
  assign bus.out_remainder = ro_q;
  assign bus.out_div_zero  = dzo_q;
endmodule

// File: tb/tb_div_int_iter.sv
// Directed + random bench for div_int_iter (WIDTH=32) against an arithmetic reference model.
module tb_div_int_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  div_int_if #(.WIDTH(W)) bus ();

  div_int_iter #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    longint sa, sb;
    longint mag;
    int     len;
    sa  = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb  = sg ? longint'($signed(b)) : longint'({32'd0, b});
    dz  = 1'b0;
    lat = 2;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0;
    end else begin
      q   = 32'(sa / sb);
      r   = 32'(sa % sb);
      mag = (sa < 0) ? -sa : sa;
      len = 0;
      while (mag > 0) begin len++; mag = mag / 2; end
      if (len == 0) len = 1;
`ifdef DIV_INT_EARLY_OUT_EN
      lat = len + 2;
`else
      lat = W + 2;
`endif
    end
  endfunction

  task automatic run(input string tag, input bit sg, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er;
    logic         edz;
    int           elat, lat;
    model(sg, a, b, eq, er, edz, elat);
    @(negedge clk);
    chk({tag, ".rdy_in"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_signed = sg;
    bus.in_dividend = a; bus.in_divisor = b; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".q"},   64'(bus.out_quotient), 64'(eq));
    chk({tag, ".r"},   64'(bus.out_remainder), 64'(er));
    chk({tag, ".dz"},  64'(bus.out_div_zero), 64'(edz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_vld"}, 64'(bus.out_valid), 64'd1);
      chk({tag, ".hold_rdy"}, 64'(bus.in_ready), 64'd0);
      chk({tag, ".hold_q"},   64'(bus.out_quotient), 64'(eq));
      chk({tag, ".hold_r"},   64'(bus.out_remainder), 64'(er));
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".drain_vld"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".drain_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rs;
    bus.in_valid = 1'b0; bus.in_signed = 1'b0; bus.in_dividend = '0;
    bus.in_divisor = '0; bus.kill = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.rdy", 64'(bus.in_ready), 64'd1);
    chk("rst.vld", 64'(bus.out_valid), 64'd0);
    chk("rst.q",   64'(bus.out_quotient), 64'd0);
    chk("rst.r",   64'(bus.out_remainder), 64'd0);
    chk("rst.dz",  64'(bus.out_div_zero), 64'd0);

    run("u100_7",   1'b0, 32'd100, 32'd7, 0);
    run("sm7_2",    1'b1, -32'sd7, 32'd2, 0);
    run("s7_m2",    1'b1, 32'd7, -32'sd2, 0);
    run("dz",       1'b0, 32'h1234, 32'd0, 0);
    run("sdz_neg",  1'b1, 32'hFFFF_FFF0, 32'd0, 0);
    run("smin_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("umin_m1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("hold5",    1'b0, 32'd1000, 32'd33, 5);
    run("u5_2",     1'b0, 32'd5, 32'd2, 0);
    run("zero_dvd", 1'b1, 32'd0, 32'd9, 0);
    run("umax_1",   1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run("smin_3",   1'b1, 32'h8000_0000, 32'd3, 0);

    // kill during CALC: accept edge, PREP edge, then 10 CALC edges
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_signed = 1'b0;
    bus.in_dividend = 32'd100; bus.in_divisor = 32'd7;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); bus.kill = 1'b1;
    @(posedge clk); #1 bus.kill = 1'b0;
    chk("kill.rdy", 64'(bus.in_ready), 64'd1);
    chk("kill.vld", 64'(bus.out_valid), 64'd0);
    repeat (40) @(posedge clk);
    #1 chk("kill.no_vld", 64'(bus.out_valid), 64'd0);
    run("post_kill", 1'b0, 32'd9, 32'd3, 0);

    // kill beats in_valid in IDLE
    @(negedge clk);
    bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    chk("kill_idle.rdy", 64'(bus.in_ready), 64'd1);

    // reset mid-operation
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_signed = 1'b1;
    bus.in_dividend = 32'd77; bus.in_divisor = 32'd5;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst.rdy", 64'(bus.in_ready), 64'd1);
    chk("mrst.vld", 64'(bus.out_valid), 64'd0);
    chk("mrst.q",   64'(bus.out_quotient), 64'd0);
    repeat (40) @(posedge clk);
    #1 chk("mrst.no_vld", 64'(bus.out_valid), 64'd0);

    for (int n = 0; n < 20; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case (n % 5)
        1: rb = rb >> $urandom_range(8, 30);
        2: ra = ra >> $urandom_range(4, 28);
        3: rb = 32'($urandom_range(0, 3));
        default: ;
      endcase
      run("rand", rs, ra, rb, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
